// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART-to-SRAM boot loader: FSM state encoding,
// word-packing constants and the byte-pair packing helper.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_LO = 3'd1,
        WAIT_HI = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } loader_state_t;

    localparam int BYTES_PER_WORD = 2;
    localparam int BYTE_WIDTH     = 8;

    // First received byte becomes the least significant byte (little-endian).
    function automatic logic [15:0] pack_word(input logic [7:0] lo_byte,
                                              input logic [7:0] hi_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/uart_sram_loader.sv
// Boot-time loader: captures LOAD_WORDS byte pairs from the UART receiver,
// packs them little-endian into SRAM words and writes them to addresses
// 0..LOAD_WORDS-1, one write-enable pulse per word.
// Optional feature macro: UART_LOADER_TIMEOUT_EN adds an inter-byte timeout
// that abandons the load after TIMEOUT_CYCLES idle clocks. Without it the
// loader waits indefinitely and 'timeout' is tied low.
module uart_sram_loader
    import uart_loader_pkg::*;
#(
    parameter int MEMORY_ADDR_WIDTH = 18,
    parameter int MEMORY_DATA_WIDTH = 16,
    parameter int LOAD_WORDS        = 1024,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic                         UART_initialize,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_byte,
    output logic                         UART_enable,
    output logic [MEMORY_ADDR_WIDTH-1:0] SRAM_address,
    output logic [MEMORY_DATA_WIDTH-1:0] SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic                         load_done,
    output logic                         overrun,
    output logic                         timeout
);

    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int DW = MEMORY_DATA_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(LOAD_WORDS - 1);

    // Reject configurations the datapath cannot represent.
    if (DW != BYTES_PER_WORD * BYTE_WIDTH) begin : g_bad_data_width
        $error("uart_sram_loader: MEMORY_DATA_WIDTH must be two bytes");
    end
    if ((LOAD_WORDS < 1) || (LOAD_WORDS > 2**AW)) begin : g_bad_load_words
        $error("uart_sram_loader: LOAD_WORDS out of range for address width");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_sram_loader: TIMEOUT_CYCLES must be at least 1");
    end

    loader_state_t   state_q, state_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [7:0]      lo_q,    lo_d;
    logic            we_n_q,  we_n_d;
    logic            en_q,    en_d;
    logic            done_q,  done_d;
    logic            ovr_q,   ovr_d;
    logic            timeout_fire_s;

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q,  to_d;
    logic             waiting_s;

    // Inter-byte idle counter and sticky timeout flag; a byte arriving in the
    // same cycle as expiry wins and restarts the count.
    always_comb begin
        cnt_d          = cnt_q;
        to_d           = to_q;
        waiting_s      = (state_q == WAIT_LO) || (state_q == WAIT_HI);
        timeout_fire_s = 1'b0;
        if ((state_q == IDLE) && UART_initialize) begin
            cnt_d = '0;
            to_d  = 1'b0;
        end else if (waiting_s) begin
            if (rx_valid) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                timeout_fire_s = 1'b1;
                to_d           = 1'b1;
                cnt_d          = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timeout counter registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign timeout_fire_s = 1'b0;
    assign timeout        = 1'b0;
`endif

    // Load sequencing: byte capture, word packing, write pulse and address step.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lo_d    = lo_q;
        we_n_d  = 1'b1;
        done_d  = done_q;
        ovr_d   = ovr_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // A byte strobe coinciding with the start request is not captured.
                if (UART_initialize) begin
                    state_d = WAIT_LO;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    ovr_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_byte;
                    state_d = WAIT_HI;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_HI: begin
                if (rx_valid) begin
                    data_d  = pack_word(lo_q, rx_byte);
                    we_n_d  = 1'b0;
                    state_d = WRITE;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WRITE: begin
                // The SRAM port is busy this cycle, so an arriving byte is lost.
                if (rx_valid) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = WAIT_LO;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout_fire_s) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end

        if ((state_d == WAIT_LO) || (state_d == WAIT_HI) || (state_d == WRITE)) begin
            en_d = 1'b1;
        end else begin
            en_d = 1'b0;
        end
    end

    // Loader state and registered outputs.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            lo_q    <= 8'h00;
            we_n_q  <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            we_n_q  <= we_n_d;
            en_q    <= en_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign UART_enable     = en_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = data_q;
    assign SRAM_we_n       = we_n_q;
    assign load_done       = done_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_uart_sram_loader.sv
// Scoreboard bench for uart_sram_loader: stimulus updates a transaction-level
// model of the load and queues the expected SRAM writes; a negedge monitor
// pops and compares every write and checks the status outputs each cycle.
module tb_uart_sram_loader;

    localparam int AW = 2;
    localparam int DW = 16;
    localparam int LW = 4;      // equals 2**AW: last address is all ones
    localparam int TC = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          uart_en;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;
    logic          sram_we_n;
    logic          load_done;
    logic          overrun;
    logic          timeout;

    always #5 clk = ~clk;

    uart_sram_loader #(
        .MEMORY_ADDR_WIDTH(AW),
        .MEMORY_DATA_WIDTH(DW),
        .LOAD_WORDS(LW),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .UART_initialize(init),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .UART_enable(uart_en),
        .SRAM_address(sram_addr),
        .SRAM_write_data(sram_data),
        .SRAM_we_n(sram_we_n),
        .load_done(load_done),
        .overrun(overrun),
        .timeout(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of one load, at transaction level.
    bit            m_loading;
    bit            m_have_lo;
    bit            m_write;
    bit            m_in_done;
    bit            m_done;
    bit            m_ovr;
    bit            m_to;
    int            m_words;
    int            m_idle;
    logic [7:0]    m_lo;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0; m_have_lo = 1'b0; m_write = 1'b0; m_in_done = 1'b0;
        m_done = 1'b0; m_ovr = 1'b0; m_to = 1'b0; m_words = 0; m_idle = 0; m_lo = 8'h00;
        exp_q.delete();
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_apply(input logic i, input logic v, input logic [7:0] b);
        if (m_write) begin
            if (v) m_ovr = 1'b1;
            m_write = 1'b0;
            m_words++;
            if (m_words == LW) begin
                m_loading = 1'b0; m_done = 1'b1; m_in_done = 1'b1;
            end
        end else if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (!m_loading) begin
            if (i) begin
                m_loading = 1'b1; m_words = 0; m_have_lo = 1'b0;
                m_done = 1'b0; m_ovr = 1'b0; m_to = 1'b0; m_idle = 0;
            end
        end else begin
            if (v) begin
                m_idle = 0;
                if (!m_have_lo) begin
                    m_lo = b; m_have_lo = 1'b1;
                end else begin
                    exp_q.push_back({AW'(m_words), b, m_lo});
                    m_have_lo = 1'b0; m_write = 1'b1;
                end
            end
`ifdef UART_LOADER_TIMEOUT_EN
            else if (m_idle == TC - 1) begin
                m_loading = 1'b0; m_have_lo = 1'b0; m_to = 1'b1;
            end else begin
                m_idle++;
            end
`endif
        end
    endtask

    // One clock of stimulus, driven just after the falling edge.
    task automatic step(input logic i, input logic v, input logic [7:0] b);
        @(negedge clk);
        #2;
        init = i; rx_valid = v; rx_byte = b;
        model_apply(i, v, b);
    endtask

    task automatic pair(input logic [7:0] lo, input logic [7:0] hi);
        step(1'b0, 1'b1, lo);
        step(1'b0, 1'b1, hi);
        step(1'b0, 1'b0, 8'h00);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset_check();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_uart_enable", uart_en, 1'b0);
        check("rst_address", sram_addr, '0);
        check("rst_write_data", sram_data, '0);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_load_done", load_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        model_reset();
        init = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: pops expected writes and checks status each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sram_we_n === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required", sram_addr, sram_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("write_addr", sram_addr, mon_w[AW+DW-1:DW]);
                    check("write_data", sram_data, mon_w[DW-1:0]);
                end
            end else if (m_loading && !m_write) begin
                check("wait_address", sram_addr, m_words);
            end
            check("uart_enable", uart_en, m_loading);
            check("load_done", load_done, m_done);
            check("overrun", overrun, m_ovr);
            check("timeout", timeout, m_to);
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        // Basic load with little-endian packing.
        step(1'b1, 1'b0, 8'h00);
        pair(8'h34, 8'h12);
        pair(8'h78, 8'h56);
        // Back-to-back bytes: the third lands in the write cycle and is dropped.
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 8'hBB);
        step(1'b0, 1'b1, 8'hCC);
        pair(8'h01, 8'h02);
        repeat (4) step(1'b0, 1'b1, 8'h77);

        // Restart clears status and begins again at address 0.
        step(1'b1, 1'b0, 8'h00);
        pair(8'hEF, 8'hBE);
        for (int k = 0; k < LW - 1; k++) pair(8'($urandom), 8'($urandom));
        repeat (2) step(1'b0, 1'b0, 8'h00);

        // Start request colliding with a byte strobe: the byte is not captured.
        step(1'b1, 1'b1, 8'h55);
        pair(8'h11, 8'h22);

        // Randomized traffic with start noise in every state.
        for (int k = 0; k < 800; k++) begin
            step(($urandom % 6) == 0, 1'($urandom % 2), 8'($urandom));
        end

        // Reset mid-word: after release a byte strobe must not write.
        async_reset_check();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        async_reset_check();
        repeat (3) step(1'b0, 1'b1, 8'h99);

        // Silence after one byte: timeout with the feature, endless wait without.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        repeat (150) step(1'b0, 1'b0, 8'h00);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
